// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and the multiply/divide unit.
package alu_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9,
    AluSra  = 4'd10,
    AluLui  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MdMult  = 3'd0,
    MdMultu = 3'd1,
    MdDiv   = 3'd2,
    MdDivu  = 3'd3,
    MdMthi  = 3'd4,
    MdMtlo  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2
  } md_state_e;

  typedef enum logic [1:0] {
    BSelRd2   = 2'd0,
    BSelImm   = 2'd1,
    BSelShamt = 2'd2,
    BSelZero  = 2'd3
  } b_sel_e;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
module mdu
  import alu_pkg::*;
#(
  parameter int unsigned Width  = 32,
  parameter int unsigned MulLat = 5,
  parameter int unsigned DivLat = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int unsigned MaxLat = (MulLat > DivLat) ? MulLat : DivLat;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  md_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic [Width-1:0] a_q, b_q, hi_q, lo_q;
  logic             sgn_q;

  logic [2*Width-1:0] ext_a, ext_b, prod;
  logic               neg_a, neg_b, div_zero;
  logic [Width-1:0]   mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;

  // Sign-extend for signed ops so a single 2W-bit multiply covers both flavours.
  always_comb begin
    ext_a    = {{Width{sgn_q & a_q[Width-1]}}, a_q};
    ext_b    = {{Width{sgn_q & b_q[Width-1]}}, b_q};
    prod     = ext_a * ext_b;
    neg_a    = sgn_q & a_q[Width-1];
    neg_b    = sgn_q & b_q[Width-1];
    mag_a    = neg_a ? -a_q : a_q;
    mag_b    = neg_b ? -b_q : b_q;
    div_zero = (b_q == '0);
    divisor  = div_zero ? Width'(1) : mag_b;
    q_mag    = mag_a / divisor;
    r_mag    = mag_a % divisor;
    // Magnitude division makes most-negative / -1 wrap back to most-negative.
    quot     = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem      = neg_a ? -r_mag : r_mag;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            case (md_op_e'(op_i))
              MdMult, MdMultu: begin
                state_q <= StMul;
                cnt_q   <= CntW'(MulLat - 1);
                a_q     <= a_i;
                b_q     <= b_i;
                sgn_q   <= (md_op_e'(op_i) == MdMult);
              end
              MdDiv, MdDivu: begin
                state_q <= StDiv;
                cnt_q   <= CntW'(DivLat - 1);
                a_q     <= a_i;
                b_q     <= b_i;
                sgn_q   <= (md_op_e'(op_i) == MdDiv);
              end
              MdMthi:  hi_q <= a_i;
              MdMtlo:  lo_q <= a_i;
              default: ;
            endcase
          end
        end
        StMul: begin
          if (cnt_q == '0) begin
            state_q      <= StIdle;
            {hi_q, lo_q} <= prod;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDiv: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            if (!div_zero) begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q != StIdle);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_ex.sv
// Execute stage: single-cycle registered ALU alongside the multi-cycle MDU.
module alu_ex
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       alu_b_sel,
  input  logic [3:0]       alu_op,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_valid,
  output logic             ovf,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] b_val, sum, diff, res;
  logic             ovf_d;
  logic [WIDTH-1:0] alu_out_q;
  logic             valid_q, ovf_q;

  always_comb begin
    b_val = '0;
    case (b_sel_e'(alu_b_sel))
      BSelRd2:   b_val = rd2;
      BSelImm:   b_val = imm;
      BSelShamt: b_val = {{(WIDTH-5){1'b0}}, imm[10:6]};
      default:   b_val = '0;
    endcase
  end

  always_comb begin
    sum   = rd1 + b_val;
    diff  = rd1 - b_val;
    res   = '0;
    ovf_d = 1'b0;
    case (alu_op_e'(alu_op))
      AluAdd: begin
        res   = sum;
        ovf_d = (rd1[WIDTH-1] == b_val[WIDTH-1]) && (sum[WIDTH-1] != rd1[WIDTH-1]);
      end
      AluSub: begin
        res   = diff;
        ovf_d = (rd1[WIDTH-1] != b_val[WIDTH-1]) && (diff[WIDTH-1] != rd1[WIDTH-1]);
      end
      AluAnd:  res = rd1 & b_val;
      AluOr:   res = rd1 | b_val;
      AluXor:  res = rd1 ^ b_val;
      AluNor:  res = ~(rd1 | b_val);
      AluSlt:  res = {{(WIDTH-1){1'b0}}, ($signed(rd1) < $signed(b_val))};
      AluSltu: res = {{(WIDTH-1){1'b0}}, (rd1 < b_val)};
      AluSll:  res = rd1 << b_val[4:0];
      AluSrl:  res = rd1 >> b_val[4:0];
      AluSra:  res = $unsigned($signed(rd1) >>> b_val[4:0]);
      AluLui:  res = b_val << 16;
      default: res = '0;
    endcase
  end

  // Result and overflow hold their last value while no new operands arrive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        alu_out_q <= res;
        ovf_q     <= ovf_d;
      end
    end
  end

  assign alu_out   = alu_out_q;
  assign alu_valid = valid_q;
  assign ovf       = ovf_q;

  mdu #(
    .Width  (WIDTH),
    .MulLat (MUL_LAT),
    .DivLat (DIV_LAT)
  ) u_mdu (
    .clk_i   (clk),
    .rst_ni  (reset),
    .start_i (md_start),
    .op_i    (md_op),
    .a_i     (rd1),
    .b_i     (b_val),
    .busy_o  (busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule

// File: tb/tb_alu_ex.sv
// Directed scoreboard bench for alu_ex: ALU vectors, MDU ops, busy timing and reset abort.
module tb_alu_ex;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] rd1, rd2, imm;
  logic [1:0]  alu_b_sel;
  logic [3:0]  alu_op;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] alu_out, hi, lo;
  logic        alu_valid, ovf, busy;

  int checks   = 0;
  int failures = 0;

  logic [32:0] alu_sb[$];
  logic [63:0] md_sb[$];

  alu_ex #(
    .WIDTH   (32),
    .MUL_LAT (5),
    .DIV_LAT (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .rd1       (rd1),
    .rd2       (rd2),
    .imm       (imm),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .md_start  (md_start),
    .md_op     (md_op),
    .alu_out   (alu_out),
    .alu_valid (alu_valid),
    .ovf       (ovf),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic alu_issue(input string tag, input logic [3:0] op, input logic [1:0] bsel,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                           input logic [31:0] exp_out, input logic exp_ovf);
    logic [32:0] e;
    alu_op    = op;
    alu_b_sel = bsel;
    rd1       = a;
    rd2       = b;
    imm       = im;
    in_valid  = 1'b1;
    alu_sb.push_back({exp_ovf, exp_out});
    step();
    in_valid = 1'b0;
    e = alu_sb.pop_front();
    check({tag, "_valid"}, 64'(alu_valid), 64'd1);
    check({tag, "_out"}, 64'(alu_out), 64'(e[31:0]));
    check({tag, "_ovf"}, 64'(ovf), 64'(e[32]));
  endtask

  task automatic md_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] bsel, input logic [31:0] im,
                          input logic [63:0] exp_hilo);
    md_op     = op;
    rd1       = a;
    rd2       = b;
    alu_b_sel = bsel;
    imm       = im;
    md_start  = 1'b1;
    md_sb.push_back(exp_hilo);
    step();
    md_start = 1'b0;
  endtask

  task automatic md_wait(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic md_pop(input string tag);
    logic [63:0] e;
    e = md_sb.pop_front();
    check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
  endtask

  task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] bsel, input logic [31:0] im,
                        input int lat, input logic [63:0] exp_hilo);
    int n;
    md_issue(op, a, b, bsel, im, exp_hilo);
    md_wait(n);
    check({tag, "_busy_cycles"}, 64'(n), 64'(lat));
    md_pop(tag);
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    in_valid  = 1'b0;
    rd1       = '0;
    rd2       = '0;
    imm       = '0;
    alu_b_sel = '0;
    alu_op    = '0;
    md_start  = 1'b0;
    md_op     = '0;
    #2;
    check("rst_alu_out", 64'(alu_out), 64'd0);
    check("rst_alu_valid", 64'(alu_valid), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    step();
    step();
    reset = 1'b1;
    step();

    alu_issue("add_ovf", AluAdd, 2'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h8000_0000, 1'b1);
    alu_issue("sra_shamt", AluSra, 2'd2, 32'h8000_0000, 32'd0, 32'h0000_0100,
              32'hF800_0000, 1'b0);
    alu_issue("sub_ovf", AluSub, 2'd0, 32'h8000_0000, 32'd1, 32'd0, 32'h7FFF_FFFF, 1'b1);
    alu_issue("add_wrap", AluAdd, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0000_0000, 1'b0);
    alu_issue("slt", AluSlt, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b0);
    alu_issue("sltu", AluSltu, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
    alu_issue("nor", AluNor, 2'd0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'd0, 32'h0000_0F0F, 1'b0);
    alu_issue("sll_b40", AluSll, 2'd0, 32'd1, 32'h23, 32'd0, 32'd8, 1'b0);
    alu_issue("srl", AluSrl, 2'd1, 32'h8000_0000, 32'd0, 32'd31, 32'd1, 1'b0);
    alu_issue("and_zero", AluAnd, 2'd3, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
    alu_issue("undef_op", 4'd15, 2'd0, 32'h1234_5678, 32'h1, 32'd0, 32'd0, 1'b0);
    alu_issue("lui", AluLui, 2'd1, 32'd0, 32'd0, 32'h0000_1234, 32'h1234_0000, 1'b0);
    step();
    check("idle_valid", 64'(alu_valid), 64'd0);
    check("idle_hold", 64'(alu_out), 64'h1234_0000);

    md_run("mult", MdMult, 32'hFFFF_FFFD, 32'd5, 2'd0, 32'd0, 5, 64'hFFFF_FFFF_FFFF_FFF1);
    md_run("multu", MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'd0, 5,
           64'hFFFF_FFFE_0000_0001);

    // Second start mid-divide must be ignored; ALU keeps working meanwhile.
    md_issue(MdDiv, 32'hFFFF_FFF9, 32'd2, 2'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD);
    md_start = 1'b1;
    md_op    = MdMultu;
    alu_issue("add_mid_div", AluAdd, 2'd0, 32'd2, 32'd3, 32'd0, 32'd5, 1'b0);
    md_start = 1'b0;
    md_wait(n);
    check("div_busy_cycles", 64'(n + 1), 64'd10);
    md_pop("div");

    md_issue(MdMthi, 32'h1234, 32'd0, 2'd0, 32'd0, 64'h0000_1234_FFFF_FFFD);
    check("mthi_busy", 64'(busy), 64'd0);
    md_pop("mthi");
    md_run("divu_zero", MdDivu, 32'd100, 32'd0, 2'd0, 32'd0, 10, 64'h0000_1234_FFFF_FFFD);
    md_run("div_minneg", MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 32'd0, 10,
           64'h0000_0000_8000_0000);
    md_run("divu_imm", MdDivu, 32'hFFFF_FFFF, 32'd0, 2'd1, 32'h10, 10,
           64'h0000_000F_0FFF_FFFF);
    md_issue(MdMtlo, 32'hABCD, 32'd0, 2'd0, 32'd0, 64'h0000_000F_0000_ABCD);
    md_pop("mtlo");

    // Abort a multiply in its third busy cycle.
    md_issue(MdMult, 32'd7, 32'd9, 2'd0, 32'd0, 64'd63);
    void'(md_sb.pop_back());
    step();
    step();
    check("abort_pre_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_alu_out", 64'(alu_out), 64'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("post_abort_busy", 64'(busy), 64'd0);
    check("post_abort_hilo", {hi, lo}, 64'd0);

    check("alu_sb_drained", 64'(alu_sb.size()), 64'd0);
    check("md_sb_drained", 64'(md_sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ex.md
ALU_EX -- requirements
Module: alu_ex

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (>= 16).
REQ-002 Parameter MUL_LAT, default 5, multiply busy cycles (>= 1).
REQ-003 Parameter DIV_LAT, default 10, divide busy cycles (>= 1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  ALU operands valid this cycle.
REQ-007 rd1  input  WIDTH  operand A.
REQ-008 rd2  input  WIDTH  register operand B.
REQ-009 imm  input  WIDTH  extended immediate.
REQ-010 alu_b_sel  input  2  B source: 0 rd2, 1 imm, 2 shamt = zero-extended imm[10:6], 3 zero.
REQ-011 alu_op  input  4  ALU operation code.
REQ-012 md_start  input  1  request MDU operation.
REQ-013 md_op  input  3  MDU code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-014 alu_out  output  WIDTH  registered ALU result.
REQ-015 alu_valid  output  1  alu_out valid.
REQ-016 ovf  output  1  registered signed overflow of ADD/SUB.
REQ-017 busy  output  1  MDU operation in progress.
REQ-018 hi, lo  output  WIDTH each  current HI/LO registers.

Function
REQ-019 ALU ops SHALL be ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI (B<<16); undefined codes yield 0.
REQ-020 Shifts SHALL use B[4:0] as amount, A as data; ADD/SUB wrap modulo 2^WIDTH.
REQ-021 alu_out, ovf and alu_valid SHALL update one cycle after in_valid=1 (latency 1); alu_valid deasserts the cycle after in_valid=0, alu_out holds.
REQ-022 ovf SHALL be 1 only for ADD/SUB with signed overflow; 0 otherwise.
REQ-023 MDU FSM states IDLE, MUL, DIV; IDLE->MUL on md_start with MULT/MULTU, IDLE->DIV on DIV/DIVU; operands latched from rd1 and selected B at the start edge.
REQ-024 busy SHALL be 1 from the cycle after start for exactly MUL_LAT or DIV_LAT cycles; HI/LO update on the edge that returns FSM to IDLE.
REQ-025 MULT/MULTU SHALL write {HI,LO} = 2*WIDTH-bit signed/unsigned product.
REQ-026 DIV/DIVU SHALL write LO = quotient (truncate toward zero), HI = remainder (sign of dividend).
REQ-027 Divide by zero SHALL complete with normal latency and leave HI/LO unchanged.
REQ-028 Signed most-negative / -1 SHALL give LO = most-negative, HI = 0.
REQ-029 MTHI/MTLO in IDLE SHALL write rd1 to HI/LO on the next edge, no busy.
REQ-030 md_start while busy SHALL be ignored; ALU path operates independently of MDU.

Reset
REQ-031 On reset low: alu_out=0, alu_valid=0, ovf=0, busy=0, hi=0, lo=0, FSM=IDLE, counter=0, immediately and asynchronously.
REQ-032 Reset mid-operation SHALL abort the operation with no HI/LO update.

Structure
REQ-033 alu_op/md_op encodings and FSM state enum SHALL live in shared package alu_pkg.
REQ-034 MDU SHALL be sub-module mdu (FSM, counter, HI/LO); combinational ALU core stays in alu_ex.

Verification
REQ-035 ADD rd1=0x7FFFFFFF, rd2=1, b_sel=0 -> next cycle alu_out=0x80000000, ovf=1, alu_valid=1.
REQ-036 SRA rd1=0x80000000, b_sel=2, imm[10:6]=4 -> alu_out=0xF8000000.
REQ-037 MULT rd1=-3, rd2=5 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-038 DIV rd1=-7, rd2=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; second md_start mid-op ignored.
REQ-039 DIVU by zero after MTHI 0x1234 -> HI stays 0x1234, busy drops after 10 cycles.
REQ-040 Reset pulsed at cycle 3 of MULT -> busy=0, hi=lo=0 immediately; no later update.
